// File: rtl/prog_nibble_mem.sv
// 16 x 4-bit program memory with a serial loader that holds the CPU in reset until loaded.
// Optional running checksum of loaded nibbles: define PROG_NIBBLE_MEM_CHECKSUM_EN.
module prog_nibble_mem #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned DEPTH       = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] rd_addr,
  output logic [3:0] rd_data,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [3:0] load_data,
  input  logic       load_done,
  output logic       cpu_reset,
  output logic       loading,
  output logic [3:0] wr_ptr,
  output logic [3:0] checksum
);

  localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    StLoad,
    StHold,
    StRun
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] mem_q [DEPTH];
  logic       cpu_reset_q, loading_q;
  logic       wr_en;
  logic [3:0] wr_addr;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    wr_en      = 1'b0;
    wr_addr    = wr_ptr_q;
    unique case (state_q)
      StLoad: begin
        // A restart redirects any same-cycle write to address 0.
        if (load_start) begin
          wr_addr  = 4'h0;
          wr_ptr_d = 4'h0;
        end
        if (load_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_addr + 4'h1;
          if (wr_addr == 4'hf) state_d = StHold;
        end
        if (load_done) state_d = StHold;
      end
      StHold: begin
        if (load_start) begin
          state_d    = StLoad;
          wr_ptr_d   = 4'h0;
          hold_cnt_d = 4'h0;
        end else if (hold_cnt_q == HoldLast) begin
          state_d    = StRun;
          hold_cnt_d = 4'h0;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'h1;
        end
      end
      StRun: begin
        if (load_start) begin
          state_d  = StLoad;
          wr_ptr_d = 4'h0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StLoad;
      wr_ptr_q    <= 4'h0;
      hold_cnt_q  <= 4'h0;
      cpu_reset_q <= 1'b1;
      loading_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      // Registered from next state so the first RUN cycle already sees cpu_reset low.
      cpu_reset_q <= (state_d != StRun);
      loading_q   <= (state_d == StLoad);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'h0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= load_data;
    end
  end

  // Reads return a NOP outside RUN, so a read never races a write.
  assign rd_data   = (state_q == StRun) ? mem_q[rd_addr] : 4'h0;
  assign cpu_reset = cpu_reset_q;
  assign loading   = loading_q;
  assign wr_ptr    = wr_ptr_q;

`ifdef PROG_NIBBLE_MEM_CHECKSUM_EN
  logic [3:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (load_start) checksum_d = 4'h0;
    if (wr_en) checksum_d = checksum_d + load_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= 4'h0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 4'h0;
`endif

endmodule
